// File: rtl/decode_stage_pipe.sv
// LEGv8 decode stage: control decode, sign extension, register file with write-back bypass, ID/EX register.
// Latency: 1 cycle from in_valid && in_ready to out_valid; load-use hazard inserts one bubble.
// Backpressure: the bundle holds while out_valid && !out_ready; in_ready drops on hold, hazard or flush.
module decode_stage_pipe #(
  parameter int WORD      = 64,
  parameter int INSTR_LEN = 32,
  parameter int NUM_REGS  = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [INSTR_LEN-1:0]        instruction,
  input  logic                        flush,
  input  logic                        wb_en,
  input  logic [$clog2(NUM_REGS)-1:0] wb_addr,
  input  logic [WORD-1:0]             wb_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [10:0]                 opcode,
  output logic [WORD-1:0]             sign_extended_output,
  output logic [WORD-1:0]             read_data1,
  output logic [WORD-1:0]             read_data2,
  output logic [4:0]                  out_rd,
  output logic                        reg2_loc,
  output logic                        uncondbranch,
  output logic                        branch,
  output logic                        mem_read,
  output logic                        mem_to_reg,
  output logic                        mem_write,
  output logic                        alu_src,
  output logic                        reg_write,
  output logic [1:0]                  alu_op
);

  localparam int XZR = NUM_REGS - 1;

  typedef struct packed {
    logic       reg2_loc;
    logic       uncondbranch;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic [1:0] alu_op;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
  } ctrl_t;

  typedef struct packed {
    ctrl_t           ctrl;
    logic [10:0]     opcode;
    logic [WORD-1:0] imm;
    logic [WORD-1:0] rd1;
    logic [WORD-1:0] rd2;
    logic [4:0]      rd;
  } bundle_t;

  logic [WORD-1:0] regs [0:NUM_REGS-2];
  bundle_t         dec;
  bundle_t         q;
  logic [4:0]      rn;
  logic [4:0]      rm;
  logic            advance;
  logic            hazard;

  // XZR reads zero; a same-cycle write to the read address is forwarded.
  function automatic logic [WORD-1:0] rf_read(input logic [4:0] a);
    if (int'(a) >= XZR) return '0;
    if (wb_en && int'(wb_addr) == int'(a)) return wb_data;
    return regs[a];
  endfunction

  always_comb begin
    dec        = '0;
    dec.opcode = instruction[31:21];
    dec.rd     = instruction[4:0];
    casez (instruction[31:21])
      11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000: begin
        dec.ctrl.alu_op    = 2'b10;
        dec.ctrl.reg_write = 1'b1;
      end
      11'b11111000010: begin
        dec.ctrl.mem_read   = 1'b1;
        dec.ctrl.mem_to_reg = 1'b1;
        dec.ctrl.alu_src    = 1'b1;
        dec.ctrl.reg_write  = 1'b1;
        dec.imm = {{(WORD-9){instruction[20]}}, instruction[20:12]};
      end
      11'b11111000000: begin
        dec.ctrl.reg2_loc  = 1'b1;
        dec.ctrl.mem_write = 1'b1;
        dec.ctrl.alu_src   = 1'b1;
        dec.imm = {{(WORD-9){instruction[20]}}, instruction[20:12]};
      end
      11'b10110100???: begin
        dec.ctrl.reg2_loc = 1'b1;
        dec.ctrl.branch   = 1'b1;
        dec.ctrl.alu_op   = 2'b01;
        dec.imm = {{(WORD-19){instruction[23]}}, instruction[23:5]};
      end
      11'b000101?????: begin
        dec.ctrl.uncondbranch = 1'b1;
        dec.imm = {{(WORD-26){instruction[25]}}, instruction[25:0]};
      end
      default: ;
    endcase
    rn      = instruction[9:5];
    rm      = dec.ctrl.reg2_loc ? instruction[4:0] : instruction[20:16];
    dec.rd1 = rf_read(rn);
    dec.rd2 = rf_read(rm);
  end

  assign advance  = !out_valid || out_ready;
  assign hazard   = out_valid && q.ctrl.mem_read && (int'(q.rd) != XZR) &&
                    (q.rd == rn || q.rd == rm);
  assign in_ready = !rst && advance && !hazard && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS - 1; i++) regs[i] <= '0;
    end else if (wb_en && int'(wb_addr) < XZR) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Flush beats hold and load; a hazard with a free output slot inserts a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      q         <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (advance) begin
      if (hazard) begin
        out_valid <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) q <= dec;
      end
    end
  end

  assign opcode               = q.opcode;
  assign sign_extended_output = q.imm;
  assign read_data1           = q.rd1;
  assign read_data2           = q.rd2;
  assign out_rd               = q.rd;
  assign reg2_loc             = q.ctrl.reg2_loc;
  assign uncondbranch         = q.ctrl.uncondbranch;
  assign branch               = q.ctrl.branch;
  assign mem_read             = q.ctrl.mem_read;
  assign mem_to_reg           = q.ctrl.mem_to_reg;
  assign alu_op               = q.ctrl.alu_op;
  assign mem_write            = q.ctrl.mem_write;
  assign alu_src              = q.ctrl.alu_src;
  assign reg_write            = q.ctrl.reg_write;

endmodule
